// File: rtl/demux1x8_rr_sched.sv
// Round-robin / fixed-priority scheduler feeding a 1x8 demux.
// One-entry output register; destination frozen once chosen.
module demux1x8_rr_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [7:0]       out_ready,
  output logic [7:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_ptr;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_cand;
  logic             w_found;
  logic             w_any_rdy;
  logic             w_xfer;
  logic             w_acc;

  assign w_any_rdy = |out_ready;
  assign w_xfer    = (r_state == S_FULL) && out_ready[r_sel];
  assign in_ready  = rst_n && w_any_rdy &&
                     ((r_state == S_EMPTY) || w_xfer);
  assign w_acc     = in_valid && in_ready;

  // Round-robin scans ptr+1 .. ptr+8; offset 8 wraps to ptr itself.
  always_comb begin
    logic [2:0] v_idx;
    v_idx   = 3'd0;
    w_cand  = 3'd0;
    w_found = 1'b0;
    if (mode) begin
      for (int i = 7; i >= 0; i--) begin
        if (out_ready[i]) w_cand = 3'(i);
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        v_idx = r_ptr + 3'(k);
        if (!w_found && out_ready[v_idx]) begin
          w_cand  = v_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc)       w_state_nxt = S_FULL;
    else if (w_xfer) w_state_nxt = S_EMPTY;
  end

  always_comb begin
    out_valid = 8'h00;
    if (r_state == S_FULL) out_valid = 8'b1 << r_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= 3'd0;
      r_ptr  <= 3'd7;
    end else if (w_acc) begin
      r_data <= in_data;
      r_sel  <= w_cand;
      r_ptr  <= w_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_xfer) r_cnt <= r_cnt + 1'b1;
  end

  assign out_data = r_data;
  assign sel      = r_sel;
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_demux1x8_rr_sched.sv
// Bench for demux1x8_rr_sched: per-cycle vector table plus
// a data scoreboard and a counter-wrap / reset-flush sequence.
module tb_demux1x8_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] out_ready = 8'h00;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic [3:0] xfer_cnt;

  demux1x8_rr_sched #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       md;
    logic       iv;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       ir;
    logic [7:0] ov;
    logic [2:0] sl;
    logic [3:0] cnt;
    logic [7:0] od;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] sb[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic v,
                     input logic [7:0] d, input logic [7:0] o,
                     input logic ir, input logic [7:0] ov,
                     input logic [2:0] sl, input logic [3:0] c,
                     input logic [7:0] od);
    vec_t x;
    x = '{r, m, v, d, o, ir, ov, sl, c, od};
    tv.push_back(x);
  endtask

  // One cycle: drive after the edge, sample and score at negedge.
  task automatic cyc(input logic r, input logic m, input logic v,
                     input logic [7:0] d, input logic [7:0] o);
    logic [7:0] e;
    @(posedge clk);
    #1;
    rst_n = r; mode = m; in_valid = v;
    in_data = d; out_ready = o;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid != 8'h00 && out_ready[sel]) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(out_data), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(e));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  endtask

  initial begin
    // reset with traffic offered
    add(0,0,1,8'hA0,8'hFF, 0,8'h00,0,0,8'h00);
    add(0,0,1,8'hA0,8'hFF, 0,8'h00,0,0,8'h00);
    // round-robin sweep A0..A9
    add(1,0,1,8'hA0,8'hFF, 1,8'h00,0,0,8'h00);
    for (int k = 1; k <= 9; k++)
      add(1,0,1,8'(8'hA0 + k),8'hFF, 1,
          8'(8'b1 << ((k-1) % 8)), 3'((k-1) % 8),
          4'(k-1), 8'(8'hA0 + k - 1));
    add(1,0,0,8'h00,8'hFF, 1,8'h02,1,9,8'hA9);
    add(1,0,0,8'h00,8'hFF, 1,8'h00,1,10,8'hA9);
    // skip busy lanes
    add(1,0,1,8'hB0,8'h54, 1,8'h00,1,10,8'hA9);
    add(1,0,1,8'hB1,8'h54, 1,8'h04,2,10,8'hB0);
    add(1,0,1,8'hB2,8'h54, 1,8'h10,4,11,8'hB1);
    add(1,0,1,8'hB3,8'h54, 1,8'h40,6,12,8'hB2);
    add(1,0,0,8'h00,8'h54, 1,8'h04,2,13,8'hB3);
    // backpressure hold, no reroute to lane 5
    add(1,0,1,8'h5A,8'h08, 1,8'h00,2,14,8'hB3);
    for (int k = 0; k < 4; k++)
      add(1,0,1,8'h77,8'h20, 0,8'h08,3,14,8'h5A);
    add(1,0,0,8'h00,8'h08, 1,8'h08,3,14,8'h5A);
    add(1,0,0,8'h00,8'h00, 0,8'h00,3,15,8'h5A);
    // fixed priority
    add(1,1,1,8'hC0,8'h90, 1,8'h00,3,15,8'h5A);
    add(1,1,1,8'hC1,8'h90, 1,8'h10,4,15,8'hC0);
    add(1,1,1,8'hC2,8'h90, 1,8'h10,4,0,8'hC1);
    add(1,1,0,8'h00,8'h90, 1,8'h10,4,1,8'hC2);
    add(1,1,1,8'hC3,8'h80, 1,8'h00,4,2,8'hC2);
    add(1,1,0,8'h00,8'h80, 1,8'h80,7,2,8'hC3);
    add(1,1,0,8'h00,8'h00, 0,8'h00,7,3,8'hC3);
    // back to round-robin: ptr kept at 7, so lane 0 next
    add(1,0,1,8'hD0,8'hFF, 1,8'h00,7,3,8'hC3);
    add(1,0,0,8'h00,8'hFF, 1,8'h01,0,3,8'hD0);
    add(1,0,0,8'h00,8'hFF, 1,8'h00,0,4,8'hD0);

    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].md, tv[i].iv, tv[i].d, tv[i].ordy);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tv[i].sl));
      chk($sformatf("v%0d_cnt", i), 32'(xfer_cnt), 32'(tv[i].cnt));
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tv[i].od));
    end

    // counter wrap: 17 transfers on a 4-bit counter
    cyc(0,0,0,8'h00,8'hFF);
    for (int k = 0; k < 17; k++) begin
      cyc(1,0,1,8'(8'hE0 + k),8'hFF);
      chk("wrap_in_ready", 32'(in_ready), 32'd1);
    end
    cyc(1,0,0,8'h00,8'hFF);
    cyc(1,0,0,8'h00,8'h00);
    chk("wrap_cnt", 32'(xfer_cnt), 32'd1);
    chk("wrap_empty", 32'(out_valid), 32'h00);

    // reset while FULL discards the word
    cyc(1,0,1,8'h3C,8'h04);
    chk("flush_accept", 32'(in_ready), 32'd1);
    cyc(0,0,0,8'h00,8'h04);
    chk("flush_held", 32'(out_valid), 32'h04);
    chk("flush_rst_ir", 32'(in_ready), 32'd0);
    cyc(1,0,0,8'h00,8'h04);
    chk("flush_ov", 32'(out_valid), 32'h00);
    chk("flush_cnt", 32'(xfer_cnt), 32'd0);
    chk("flush_ptr_rst", 32'(in_ready), 32'd1);
    cyc(1,0,0,8'h00,8'h04);
    chk("flush_never", 32'(out_valid), 32'h00);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
